pll_lock_reset_seq: RTL and testbench

PLL_LOCK_RESET_SEQ -- requirements
Module: pll_lock_reset_seq

---
 rtl/pll_rst_pkg.sv | 25 ++
 rtl/pll_lock_reset_seq_sync_2ff.sv | 21 ++
 rtl/pll_lock_reset_seq.sv | 96 +++++++++
 tb/tb_pll_lock_reset_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// Shared state encoding, default timing constants and counter sizing for pll_lock_reset_seq.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } pll_state_e;

    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT   = 65536;
    localparam int LOSS_CNT_W         = 8;

    // The counter only ever reaches (limit - 1), so clog2 of the largest limit is enough.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_lock_reset_seq_sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous clear, used for the PLL lock indicator.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_reset_seq.sv
// PLL reset / lock-qualification sequencer producing the PLL reset, system reset and ready.
// Define LOCK_LOSS_CNT_EN to add the saturating loss_cnt port and counter.
module pll_lock_reset_seq
    import pll_rst_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       clr_lost,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_lost
`ifdef LOCK_LOSS_CNT_EN
    ,
    output logic [LOSS_CNT_W-1:0] loss_cnt
`endif
);

    localparam int CW = cnt_width(PLL_RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT);

    pll_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lock_s;
    logic          loss_evt;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        loss_evt = 1'b0;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == CW'(PLL_RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s)                             state_d = ST_STABLE;
                else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) state_d = ST_PLL_RST;
            end
            ST_STABLE: begin
                if (!lock_s)                             state_d = ST_WAIT_LOCK;
                else if (cnt_q == CW'(STABLE_CYCLES - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                // RUN has no timer; parking the counter keeps it from wrapping.
                cnt_d = '0;
                if (!lock_s) begin
                    state_d  = ST_PLL_RST;
                    loss_evt = 1'b1;
                end
            end
            default: state_d = ST_PLL_RST;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs decode the next state so they switch on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_PLL_RST;
            cnt_q     <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pll_rst <= (state_d == ST_PLL_RST);
            sys_rst <= (state_d != ST_RUN);
            ready   <= (state_d == ST_RUN);
            if (loss_evt)      lock_lost <= 1'b1;
            else if (clr_lost) lock_lost <= 1'b0;
        end
    end

`ifdef LOCK_LOSS_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            loss_cnt <= '0;
        else if (loss_evt && (loss_cnt != {LOSS_CNT_W{1'b1}}))
            loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Self-checking bench for pll_lock_reset_seq: directed table, edge-timing sequences and a
// randomized run compared against a deadline-based reference model.
module tb_pll_lock_reset_seq;

    localparam int P = 16;
    localparam int S = 40;
    localparam int T = 100;

    localparam int PH_RST    = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_SETTLE = 2;
    localparam int PH_RUN    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pll_locked = 1'b0;
    logic clr_lost = 1'b0;
    logic pll_rst, sys_rst, ready, lock_lost;
`ifdef LOCK_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_lock_reset_seq #(
        .PLL_RST_CYCLES (P),
        .STABLE_CYCLES  (S),
        .LOCK_TIMEOUT   (T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .clr_lost   (clr_lost),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .lock_lost  (lock_lost)
`ifdef LOCK_LOSS_CNT_EN
        ,
        .loss_cnt   (loss_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: lock seen two edges late, each phase ends at an absolute edge number.
    int  cyc = 0;
    int  ph = PH_RST;
    int  ph_at = 0;
    bit  lk_q[$];
    bit  m_lost = 1'b0;
    int  m_loss = 0;
    bit  mdl_en = 1'b0;

    task automatic enter(input int nph);
        ph    = nph;
        ph_at = cyc;
    endtask

    always @(posedge clk) begin
        bit ls;
        bit set_ev;
        cyc++;
        if (rst) begin
            enter(PH_RST);
            lk_q.delete();
            lk_q.push_back(1'b0);
            lk_q.push_back(1'b0);
            m_lost = 1'b0;
            m_loss = 0;
        end else begin
            ls = lk_q.pop_front();
            lk_q.push_back(pll_locked);
            set_ev = 1'b0;
            case (ph)
                PH_RST:    if (cyc == ph_at + P) enter(PH_WAIT);
                PH_WAIT:   if (ls) enter(PH_SETTLE);
                           else if (cyc == ph_at + T) enter(PH_RST);
                PH_SETTLE: if (!ls) enter(PH_WAIT);
                           else if (cyc == ph_at + S) enter(PH_RUN);
                default:   if (!ls) begin enter(PH_RST); set_ev = 1'b1; end
            endcase
            if (set_ev) begin
                m_lost = 1'b1;
                if (m_loss < 255) m_loss++;
            end else if (clr_lost) begin
                m_lost = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_en) begin
            chk("model_outputs", {28'd0, pll_rst, sys_rst, ready, lock_lost},
                {28'd0, ph == PH_RST, ph != PH_RUN, ph == PH_RUN, m_lost});
`ifdef LOCK_LOSS_CNT_EN
            chk("model_loss_cnt", {24'd0, loss_cnt}, m_loss);
`endif
        end
    end

    typedef struct {
        bit         rst;
        bit         lk;
        bit         clr;
        int         n;
        logic [3:0] exp;   // {pll_rst, sys_rst, ready, lock_lost}
        string      nm;
    } vec_t;

    vec_t tbl[12];

    // Counts edges until the selected output reaches lvl; -1 if the bound runs out.
    task automatic count_until(input int sel, input logic lvl, input int start,
                               input int lim, output int idx);
        logic v;
        idx = start;
        for (int j = 0; j < lim; j++) begin
            @(posedge clk);
            #1;
            case (sel)
                0:       v = pll_rst;
                1:       v = sys_rst;
                default: v = ready;
            endcase
            if (v === lvl) return;
            idx++;
        end
        idx = -1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        pll_locked = 1'b0;
        clr_lost   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int idx;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3,   4'b1100, "reset_state"};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 10,  4'b1100, "pll_rst_hold"};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 10,  4'b0100, "wait_lock"};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 20,  4'b0100, "stable"};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 30,  4'b0010, "run"};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 5,   4'b1101, "loss_in_run"};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1,   4'b1100, "clr_lost"};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 150, 4'b0100, "timeout_rewait"};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 60,  4'b0010, "relock_run"};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1,   4'b1100, "rst_in_run"};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 20,  4'b0100, "restart_stable"};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 50,  4'b0010, "restart_run"};

        @(negedge clk);
        mdl_en = 1'b1;

        foreach (tbl[i]) begin
            rst        = tbl[i].rst;
            pll_locked = tbl[i].lk;
            clr_lost   = tbl[i].clr;
            repeat (tbl[i].n) @(negedge clk);
            chk(tbl[i].nm, {28'd0, pll_rst, sys_rst, ready, lock_lost}, {28'd0, tbl[i].exp});
        end
        clr_lost = 1'b0;

        // Lock from reset: PLL reset width, then release exactly S+2 edges after first sample.
        do_reset();
        count_until(0, 1'b0, 1, 40, idx);
        chk("pll_rst_width", idx, P);
        @(negedge clk);
        repeat (20) @(negedge clk);
        pll_locked = 1'b1;
        count_until(1, 1'b0, 0, S + 50, idx);
        chk("lock_to_release_edges", idx, S + 2);
        chk("ready_after_release", ready, 1'b1);
        @(negedge clk);

        // Loss in RUN: takes effect on the third edge counting the sampling edge.
        pll_locked = 1'b0;
        count_until(1, 1'b1, 0, 20, idx);
        chk("loss_to_sys_rst_edges", idx, 2);
        chk("ready_after_loss", ready, 1'b0);
        chk("lock_lost_after_loss", lock_lost, 1'b1);
        chk("pll_rst_after_loss", pll_rst, 1'b1);
        @(negedge clk);

        // One-cycle lock glitch mid-settle restarts the stable count.
        do_reset();
        repeat (30) @(negedge clk);
        pll_locked = 1'b1;
        repeat (22) @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        count_until(1, 1'b0, 23, S + 60, idx);
        chk("glitch_release_edges", idx, S + 25);
        @(negedge clk);

        // No lock ever: PLL reset re-pulses every T+P edges, system stays in reset.
        do_reset();
        count_until(0, 1'b0, 1, 40, idx);
        chk("nolock_first_pulse", idx, P);
        count_until(0, 1'b1, 1, T + 20, idx);
        chk("nolock_timeout", idx, T);
        count_until(0, 1'b0, 1, 40, idx);
        chk("nolock_repulse_width", idx, P);
        count_until(0, 1'b1, 1, T + 20, idx);
        chk("nolock_timeout_2", idx, T);
        chk("nolock_sys_rst", sys_rst, 1'b1);
        @(negedge clk);

        // clr_lost on the same edge as a loss: set wins; a later lone clear works.
        do_reset();
        pll_locked = 1'b1;
        count_until(2, 1'b1, 0, 200, idx);
        chk("reach_run_for_clr", (idx >= 0), 1'b1);
        @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr_lost = 1'b1;
        @(negedge clk);
        clr_lost = 1'b0;
        chk("clr_vs_set", lock_lost, 1'b1);
        @(negedge clk);
        chk("lost_sticky", lock_lost, 1'b1);
        clr_lost = 1'b1;
        @(negedge clk);
        clr_lost = 1'b0;
        chk("lost_cleared", lock_lost, 1'b0);

`ifdef LOCK_LOSS_CNT_EN
        do_reset();
        for (int k = 1; k <= 256; k++) begin
            pll_locked = 1'b1;
            count_until(2, 1'b1, 0, 300, idx);
            if (idx < 0) chk("loss_loop_run", idx, 0);
            @(negedge clk);
            pll_locked = 1'b0;
            count_until(2, 1'b0, 0, 10, idx);
            if (idx < 0) chk("loss_loop_drop", idx, 0);
            @(negedge clk);
            if (k == 1)   chk("loss_cnt_first", loss_cnt, 8'd1);
            if (k == 255) chk("loss_cnt_255", loss_cnt, 8'd255);
            if (k == 256) chk("loss_cnt_saturate", loss_cnt, 8'd255);
        end
`endif

        // Randomized lock activity with occasional clears and reset pulses.
        for (int i = 0; i < 60; i++) begin
            pll_locked = ($urandom_range(0, 3) != 0);
            clr_lost   = ($urandom_range(0, 9) == 0);
            rst        = ($urandom_range(0, 39) == 0);
            repeat ($urandom_range(1, 80)) begin
                @(negedge clk);
                rst      = 1'b0;
                clr_lost = 1'b0;
            end
        end

        mdl_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
